tdm_ws_ctrl: RTL and testbench

Parametrised frame/word-select controller for the I2S transceiver, generalising two-channel L/R control to N-slot TDM framing.
- Master: generates the ws/frame-sync and slot/bit counters.
- Slave: locks to an external ws, checks frame alignment and flags sync errors.
- Drives Tx FIFO read enable or Rx FIFO write enable per active slot, with optional Philips one-bit delay.

---
 rtl/tdm_ws_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_tdm_ws_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tdm_ws_ctrl.sv
// I2S / N-slot TDM frame controller: master ws generation, slave ws tracking with
// alignment check, per-slot FIFO enables. Define SYNC_ERR_CNT_EN to add sync_err_cnt.
module tdm_ws_ctrl #(
  parameter int NUM_CH = 2,
  parameter int SLOT_W = 32,
  parameter int TDM    = 0,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int BIT_W  = $clog2(SLOT_W)
) (
  input  logic             sclk,
  input  logic             rst_,
  input  logic             en,
  input  logic             master,
  input  logic             tx,
  input  logic             delay1,
  input  logic [CH_W:0]    num_active,
  input  logic             ws_in,
  input  logic             tx_empty,
  input  logic             rx_full,
  output logic             ws_out,
  output logic             ws_oe,
  output logic             tx_ren,
  output logic             rx_wen,
  output logic [CH_W-1:0]  slot_idx,
  output logic [BIT_W-1:0] bit_idx,
  output logic             frame_start,
  output logic             sync_err
`ifdef SYNC_ERR_CNT_EN
  ,
  output logic [7:0]       sync_err_cnt
`endif
);
  localparam logic [CH_W-1:0]  LAST_SLOT = CH_W'(NUM_CH - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(SLOT_W - 1);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_e;

  state_e           state_q, state_d;
  logic [CH_W-1:0]  slot_q, slot_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             cfg_master_q, cfg_tx_q, cfg_delay1_q;
  logic [CH_W:0]    cfg_active_q;
  logic             ws_in_q;
  logic             ws_out_q, ws_oe_q, tx_ren_q, rx_wen_q, frame_start_q, sync_err_q;
  logic             tx_raw_q, rx_raw_q;

  logic             cfg_load, master_e, tx_e, delay1_e;
  logic [CH_W:0]    active_e;
  logic             last_pos, mid_pos, frame_edge, mid_edge, fifo_block, align_err;
  logic             run_d, slot_on_d, tx_raw_d, rx_raw_d, ws_d, tx_ren_d, rx_wen_d;

  assign last_pos   = (slot_q == LAST_SLOT) && (bit_q == LAST_BIT);
  assign mid_pos    = (slot_q == '0) && (bit_q == LAST_BIT);
  assign frame_edge = (TDM != 0) ? (!ws_in_q && ws_in) : (ws_in_q && !ws_in);
  assign mid_edge   = (TDM == 0) && !ws_in_q && ws_in;

  // Mode inputs are taken live at frame boundaries and frozen mid-frame.
  assign cfg_load   = (state_q != RUN) || last_pos;
  assign master_e   = cfg_load ? master     : cfg_master_q;
  assign tx_e       = cfg_load ? tx         : cfg_tx_q;
  assign delay1_e   = cfg_load ? delay1     : cfg_delay1_q;
  assign active_e   = cfg_load ? num_active : cfg_active_q;
  assign fifo_block = tx_e ? tx_empty : rx_full;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d   = state_q;
    slot_d    = slot_q;
    bit_d     = bit_q;
    align_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && !master_e)          state_d = SYNC;
        else if (en && !fifo_block)   state_d = RUN;
      end
      SYNC: begin
        if (!en) state_d = IDLE;
        else if (frame_edge) begin
          state_d = RUN;
          slot_d  = '0;
          bit_d   = '0;
        end
      end
      RUN: begin
        if (bit_q == LAST_BIT) begin
          bit_d  = '0;
          slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
        end else begin
          bit_d  = bit_q + 1'b1;
        end
        if (!cfg_master_q) begin
          if (frame_edge != last_pos) begin
            align_err = 1'b1;
            if (frame_edge) begin
              slot_d = '0;
              bit_d  = '0;
            end
          end else if ((TDM == 0) && (mid_edge != mid_pos)) begin
            // A misplaced mid-frame rising edge realigns to the start of slot 1.
            align_err = 1'b1;
            if (mid_edge) begin
              slot_d = CH_W'(1);
              bit_d  = '0;
            end
          end
        end
        if (last_pos && (!en || (master_e && fifo_block))) begin
          state_d = IDLE;
          slot_d  = '0;
          bit_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run_d     = (state_d == RUN);
    slot_on_d = run_d && ({1'b0, slot_d} < active_e);
    tx_raw_d  = slot_on_d && tx_e;
    rx_raw_d  = slot_on_d && !tx_e;
    tx_ren_d  = delay1_e ? tx_raw_q : tx_raw_d;
    rx_wen_d  = (delay1_e ? rx_raw_q : rx_raw_d) && !tx_ren_d;
    if (TDM != 0)
      ws_d = delay1_e ? ((slot_d == LAST_SLOT) && (bit_d == LAST_BIT))
                      : ((slot_d == '0) && (bit_d == '0));
    else
      ws_d = delay1_e ? (((slot_d == '0) && (bit_d == LAST_BIT)) ||
                         ((slot_d != '0) && (bit_d != LAST_BIT)))
                      : (slot_d != '0);
    ws_d = ws_d && run_d && master_e;
  end

  always_ff @(posedge sclk or negedge rst_) begin
    if (!rst_) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      bit_q         <= '0;
      cfg_master_q  <= 1'b0;
      cfg_tx_q      <= 1'b0;
      cfg_delay1_q  <= 1'b0;
      cfg_active_q  <= '0;
      ws_in_q       <= 1'b0;
      ws_out_q      <= 1'b0;
      ws_oe_q       <= 1'b0;
      tx_raw_q      <= 1'b0;
      rx_raw_q      <= 1'b0;
      tx_ren_q      <= 1'b0;
      rx_wen_q      <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q       <= state_d;
      slot_q        <= slot_d;
      bit_q         <= bit_d;
      ws_in_q       <= ws_in;
      if (cfg_load) begin
        cfg_master_q <= master;
        cfg_tx_q     <= tx;
        cfg_delay1_q <= delay1;
        cfg_active_q <= num_active;
      end
      ws_out_q      <= ws_d;
      ws_oe_q       <= master_e && (state_d != IDLE);
      tx_raw_q      <= tx_raw_d;
      rx_raw_q      <= rx_raw_d;
      tx_ren_q      <= tx_ren_d;
      rx_wen_q      <= rx_wen_d;
      frame_start_q <= run_d && (slot_d == '0) && (bit_d == '0);
      sync_err_q    <= en && (sync_err_q || align_err);
    end
  end

`ifdef SYNC_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge sclk or negedge rst_) begin
    if (!rst_)                                   err_cnt_q <= '0;
    else if (!en)                                err_cnt_q <= '0;
    else if (align_err && (err_cnt_q != 8'hFF))  err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign sync_err_cnt = err_cnt_q;
`endif

  assign ws_out      = ws_out_q;
  assign ws_oe       = ws_oe_q;
  assign tx_ren      = tx_ren_q;
  assign rx_wen      = rx_wen_q;
  assign slot_idx    = slot_q;
  assign bit_idx     = bit_q;
  assign frame_start = frame_start_q;
  assign sync_err    = sync_err_q;
endmodule

// File: tb/tb_tdm_ws_ctrl.sv
// Directed bench for tdm_ws_ctrl: instance A is 2ch/32b I2S, instance B is 8ch/16b TDM.
// Output vectors pack {ws_oe, ws_out, tx_ren, rx_wen, frame_start, sync_err, slot, bit}.
module tb_tdm_ws_ctrl;
  logic sclk, rst_, en, master, tx, delay1, tx_empty, rx_full, ws_in_a, ws_in_b;
  logic [1:0] na_a;
  logic [3:0] na_b;

  logic ws_out_a, ws_oe_a, tx_ren_a, rx_wen_a, fs_a, se_a;
  logic [0:0] slot_a;
  logic [4:0] bit_a;
  logic ws_out_b, ws_oe_b, tx_ren_b, rx_wen_b, fs_b, se_b;
  logic [2:0] slot_b;
  logic [3:0] bit_b;
`ifdef SYNC_ERR_CNT_EN
  logic [7:0] cnt_a, cnt_b;
`endif

  logic [31:0] vec_a, vec_b, ea, eb;
  logic [5:0]  p;
  logic        run, serr;
  int          n_checks = 0;
  int          n_fail = 0;

  tdm_ws_ctrl #(.NUM_CH(2), .SLOT_W(32), .TDM(0)) u_i2s (
    .sclk(sclk), .rst_(rst_), .en(en), .master(master), .tx(tx), .delay1(delay1),
    .num_active(na_a), .ws_in(ws_in_a), .tx_empty(tx_empty), .rx_full(rx_full),
    .ws_out(ws_out_a), .ws_oe(ws_oe_a), .tx_ren(tx_ren_a), .rx_wen(rx_wen_a),
    .slot_idx(slot_a), .bit_idx(bit_a), .frame_start(fs_a), .sync_err(se_a)
`ifdef SYNC_ERR_CNT_EN
    , .sync_err_cnt(cnt_a)
`endif
  );

  tdm_ws_ctrl #(.NUM_CH(8), .SLOT_W(16), .TDM(1)) u_tdm (
    .sclk(sclk), .rst_(rst_), .en(en), .master(master), .tx(tx), .delay1(delay1),
    .num_active(na_b), .ws_in(ws_in_b), .tx_empty(tx_empty), .rx_full(rx_full),
    .ws_out(ws_out_b), .ws_oe(ws_oe_b), .tx_ren(tx_ren_b), .rx_wen(rx_wen_b),
    .slot_idx(slot_b), .bit_idx(bit_b), .frame_start(fs_b), .sync_err(se_b)
`ifdef SYNC_ERR_CNT_EN
    , .sync_err_cnt(cnt_b)
`endif
  );

  assign vec_a = {20'b0, ws_oe_a, ws_out_a, tx_ren_a, rx_wen_a, fs_a, se_a, slot_a, bit_a};
  assign vec_b = {19'b0, ws_oe_b, ws_out_b, tx_ren_b, rx_wen_b, fs_b, se_b, slot_b, bit_b};

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Flags are {ws_oe, ws_out, tx_ren, rx_wen, frame_start, sync_err}.
  function automatic logic [31:0] pk_a(input logic [5:0] f, input logic [5:0] q);
    return {20'b0, f, q};
  endfunction

  function automatic logic [31:0] pk_b(input logic [5:0] f, input logic [6:0] q);
    return {19'b0, f, q};
  endfunction

  // Master transmit, no delay: A ws low in slot 0 / high in slot 1; B pulse at frame start.
  function automatic logic [31:0] master_a(input logic [5:0] q);
    return pk_a({1'b1, q[5], 1'b1, 1'b0, q == 6'd0, 1'b0}, q);
  endfunction

  function automatic logic [31:0] master_b(input logic [6:0] q);
    return pk_b({1'b1, q == 7'd0, q < 7'd48, 1'b0, q == 7'd0, 1'b0}, q);
  endfunction

  initial begin
    rst_ = 1'b0; en = 1'b0; master = 1'b1; tx = 1'b1; delay1 = 1'b0;
    tx_empty = 1'b0; rx_full = 1'b0; ws_in_a = 1'b0; ws_in_b = 1'b0;
    na_a = 2'd2; na_b = 4'd3;
    repeat (3) @(negedge sclk);
    check("reset_a", vec_a, 32'd0);
    check("reset_b", vec_b, 32'd0);
    rst_ = 1'b1;
    @(negedge sclk);
    en = 1'b1;

    // Free-running master frames, then en dropped at slot 0 bit 5: frames complete.
    for (int k = 0; k < 400; k++) begin
      @(negedge sclk);
      ea = (k < 320) ? master_a(6'(k)) : 32'd0;
      eb = (k < 384) ? master_b(7'(k)) : 32'd0;
      check("master_a", vec_a, ea);
      check("master_b", vec_b, eb);
      if (k == 261) en = 1'b0;
    end

    // Tx FIFO empty at A's frame end stops A; refill restarts it. B's frame end misses it.
    en = 1'b1;
    for (int k = 0; k <= 200; k++) begin
      @(negedge sclk);
      if (k < 64)       ea = master_a(6'(k));
      else if (k <= 80) ea = 32'd0;
      else              ea = master_a(6'(k - 81));
      check("guard_a", vec_a, ea);
      check("guard_b", vec_b, master_b(7'(k)));
      if (k == 10) tx_empty = 1'b1;
      if (k == 80) tx_empty = 1'b0;
    end

    // A is in slot 1 here; asynchronous reset clears everything before the next edge.
    #2 rst_ = 1'b0;
    #1;
    check("async_rst_a", vec_a, 32'd0);
    check("async_rst_b", vec_b, 32'd0);
    @(negedge sclk);
    check("rst_hold_a", vec_a, 32'd0);
    rst_ = 1'b1;
    @(negedge sclk);
    check("restart_a", vec_a, master_a(6'd0));
    check("restart_b", vec_b, master_b(7'd0));
    en = 1'b0;
    repeat (140) @(negedge sclk);
    check("idle_a", vec_a, 32'd0);
    check("idle_b", vec_b, 32'd0);

    // Philips delay on A: ws leads slot boundaries by one sclk, tx_ren lags one sclk.
    delay1 = 1'b1;
    en = 1'b1;
    for (int k = 0; k <= 200; k++) begin
      @(negedge sclk);
      p = 6'(k);
      if (k < 192)
        ea = pk_a({1'b1, (p == 6'd31) || (p[5] && p != 6'd63), k >= 1, 1'b0,
                   p == 6'd0, 1'b0}, p);
      else if (k == 192)
        ea = pk_a(6'b001000, 6'd0);
      else
        ea = 32'd0;
      check("philips_a", vec_a, ea);
      if (k == 130) en = 1'b0;
    end
    repeat (70) @(negedge sclk);
    check("philips_idle_b", vec_b, 32'd0);
    delay1 = 1'b0;

    // Slave receive on A locked to an external ws; one early falling edge injected.
    master = 1'b0; tx = 1'b0; ws_in_a = 1'b1; en = 1'b1;
    repeat (3) begin
      @(negedge sclk);
      check("sync_wait_a", vec_a, 32'd0);
    end
    ws_in_a = 1'b0;
    p = 6'd0; run = 1'b1; serr = 1'b0;
    for (int i = 0; i < 340; i++) begin
      @(negedge sclk);
      ea = run ? pk_a({1'b0, 1'b0, 1'b0, 1'b1, p == 6'd0, serr}, p) : 32'd0;
      check("slave_a", vec_a, ea);
      check("slave_b", vec_b, 32'd0);
`ifdef SYNC_ERR_CNT_EN
      if (i == 100) check("err_cnt_before", {24'd0, cnt_a}, 32'd0);
      if (i == 250) check("err_cnt_after", {24'd0, cnt_a}, 32'd1);
`endif
      if (i == 116) serr = 1'b1;
      if (i == 250) en = 1'b0;
      if (!en) serr = 1'b0;
      if (run && p == 6'd63 && !en) run = 1'b0;
      if (i == 116) begin
        ws_in_a = 1'b0;
        p = 6'd0;
      end else begin
        p = p + 6'd1;
        ws_in_a = p[5];
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
